// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decodes the immediate/target field of an instruction word,
// sign- or zero-extends it to DATA_W bits and hands it on through a 2-entry
// elastic buffer (output register + skid register) with valid/ready on both sides.
// Optional feature: define IMM_EXTEND_ZEXT_EN to make opcode ZEXT_OP select a
// zero-extended target field (out_mode 2). Without it ZEXT_OP is an ordinary
// immediate opcode and out_mode never reports 2.
module imm_extend_pipe #(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5,
  parameter int IMM_W    = 17,
  parameter int TGT_W    = 27,
  parameter int TGT_OP_A = 1,
  parameter int TGT_OP_B = 3,
  parameter int ZEXT_OP  = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_ir,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_mode,
  input  logic              out_ready
);

  localparam logic [1:0] MODE_IMM  = 2'd0;
  localparam logic [1:0] MODE_TGT  = 2'd1;
  localparam logic [1:0] MODE_ZEXT = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_mode_q, out_mode_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        skid_mode_q, skid_mode_d;
  logic              in_ready_q, in_ready_d;

  logic [OPCODE_W-1:0] opcode;
  logic                is_tgt;
  logic                is_zext;
  logic [DATA_W-1:0]   ext_data;
  logic [1:0]          ext_mode;
  logic                accept;
  logic                drain;

  assign opcode  = in_ir[DATA_W-1 -: OPCODE_W];
  assign is_tgt  = (opcode == OPCODE_W'(TGT_OP_A)) || (opcode == OPCODE_W'(TGT_OP_B));
  assign is_zext = (opcode == OPCODE_W'(ZEXT_OP));

  // Decode the format and extend the selected field; every opcode maps somewhere.
  always_comb begin
    ext_data = {{(DATA_W-IMM_W){in_ir[IMM_W-1]}}, in_ir[IMM_W-1:0]};
    ext_mode = MODE_IMM;
    if (is_tgt) begin
      ext_data = {{(DATA_W-TGT_W){in_ir[TGT_W-1]}}, in_ir[TGT_W-1:0]};
      ext_mode = MODE_TGT;
    end else if (is_zext) begin
`ifdef IMM_EXTEND_ZEXT_EN
      ext_data = {{(DATA_W-TGT_W){1'b0}}, in_ir[TGT_W-1:0]};
      ext_mode = MODE_ZEXT;
`else
      ext_data = {{(DATA_W-IMM_W){in_ir[IMM_W-1]}}, in_ir[IMM_W-1:0]};
      ext_mode = MODE_IMM;
`endif
    end
  end

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

  // Occupancy FSM and buffer next-state: new words go to the output register
  // when it is free or draining, otherwise to the skid register.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = ext_data;
          out_mode_d = ext_mode;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          skid_data_d = ext_data;
          skid_mode_d = ext_mode;
          state_d     = ST_TWO;
        end else if (accept && drain) begin
          out_data_d = ext_data;
          out_mode_d = ext_mode;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can move us.
        if (drain) begin
          out_data_d = skid_data_q;
          out_mode_d = skid_mode_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_mode_q  <= MODE_IMM;
      skid_data_q <= '0;
      skid_mode_q <= MODE_IMM;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a table of decode vectors pushed
// through an empty buffer one at a time, then hand-written back-pressure,
// flush and reset sequences.
module tb_imm_extend_pipe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ir;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic        out_ready;

  int n_vec;
  int n_fail;

  imm_extend_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ir    (in_ir),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_mode (out_mode),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] data;
    logic [1:0]  mode;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = '0;
    out_ready = 1'b0;

    vecs[0] = '{ir: 32'h0C000005, data: 32'hFC000005, mode: 2'd1};
    vecs[1] = '{ir: 32'h2801FFFF, data: 32'hFFFFFFFF, mode: 2'd0};
    vecs[2] = '{ir: 32'h2800FFFF, data: 32'h0000FFFF, mode: 2'd0};
`ifdef IMM_EXTEND_ZEXT_EN
    vecs[3] = '{ir: 32'hAC000005, data: 32'h04000005, mode: 2'd2};
`else
    vecs[3] = '{ir: 32'hAC000005, data: 32'h00000005, mode: 2'd0};
`endif
    vecs[4] = '{ir: 32'h1A000000, data: 32'h02000000, mode: 2'd1};
    vecs[5] = '{ir: 32'h0BFFFFFF, data: 32'h03FFFFFF, mode: 2'd1};
    vecs[6] = '{ir: 32'h00010000, data: 32'hFFFF0000, mode: 2'd0};
    vecs[7] = '{ir: 32'hF8000000, data: 32'h00000000, mode: 2'd0};
    vecs[8] = '{ir: 32'h1001FFFF, data: 32'hFFFFFFFF, mode: 2'd0};
    vecs[9] = '{ir: 32'h1C000000, data: 32'hFC000000, mode: 2'd1};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_data",  out_data,           32'd0);
    check("reset out_mode",  {30'd0, out_mode},  32'd0);

    // Decode table: each word into an empty buffer, visible after one edge, then drained.
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_ir     = vecs[i].ir;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d out_data", i),  out_data,           vecs[i].data);
      check($sformatf("vec%0d out_mode", i),  {30'd0, out_mode},  {30'd0, vecs[i].mode});
      out_ready = 1'b1;
      tick();
      check($sformatf("vec%0d drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: A, B, C offered while the consumer stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 32'h2800FFFF;              // A -> 0x0000FFFF
    tick();
    check("bp in_ready after A", {31'd0, in_ready}, 32'd1);
    in_ir = 32'h0C000005;                  // B -> 0xFC000005
    tick();
    check("bp in_ready after B", {31'd0, in_ready}, 32'd0);
    check("bp out_data A",       out_data,          32'h0000FFFF);
    in_ir = 32'h2801FFFF;                  // C -> 0xFFFFFFFF
    tick();
    check("bp C held off",       {31'd0, in_ready}, 32'd0);
    check("bp A stable",         out_data,          32'h0000FFFF);
    check("bp A mode stable",    {30'd0, out_mode}, 32'd0);
    out_ready = 1'b1;
    tick();                                // A drained, B promoted from skid
    check("bp out_data B",       out_data,          32'hFC000005);
    check("bp out_mode B",       {30'd0, out_mode}, 32'd1);
    check("bp in_ready reopen",  {31'd0, in_ready}, 32'd1);
    tick();                                // B drained, C accepted
    in_valid = 1'b0;
    check("bp out_data C",       out_data,          32'hFFFFFFFF);
    check("bp out_valid C",      {31'd0, out_valid}, 32'd1);
    tick();                                // C drained
    check("bp empty at end",     {31'd0, out_valid}, 32'd0);

    // Flush with two entries held and a same-cycle offer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 32'h00000011;
    tick();
    in_ir = 32'h00000022;
    tick();
    check("fl full",             {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    in_ir = 32'h00000033;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl out_valid",        {31'd0, out_valid}, 32'd0);
    check("fl in_ready",         {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    tick();
    check("fl word dropped",     {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with two entries held and an offer pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 32'h0C000005;
    tick();
    in_ir = 32'h2801FFFF;
    tick();
    check("rs full",             {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    flush = 1'b1;
    in_ir = 32'h00000044;
    tick();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("rs out_valid",        {31'd0, out_valid}, 32'd0);
    check("rs in_ready",         {31'd0, in_ready},  32'd1);
    check("rs out_data",         out_data,           32'd0);
    check("rs out_mode",         {30'd0, out_mode},  32'd0);
    out_ready = 1'b1;
    tick();
    check("rs stays empty",      {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
